// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter in front of a single-ported
//                data memory. Each granted request runs IDLE -> ACCESS -> DONE
//                with a one-cycle Ack pulse, and per-port completion counters.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    // port 0 (core load/store)
    input  logic       Req0,
    input  logic       We0,
    input  logic [7:0] Addr0,
    input  logic [7:0] Wdata0,
    output logic       Ack0,
    output logic [7:0] Rdata0,
    // port 1 (loader/debug)
    input  logic       Req1,
    input  logic       We1,
    input  logic [7:0] Addr1,
    input  logic [7:0] Wdata1,
    output logic       Ack1,
    output logic [7:0] Rdata1,
    // data memory side
    output logic       MemWriteEn,
    output logic       MemToReg,
    output logic [7:0] MemAddress,
    output logic [7:0] MemDataIn,
    input  logic [7:0] MemDataOut,
    // status
    output logic [7:0] Count0,
    output logic [7:0] Count1,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_gnt_q, last_gnt_d;   // port granted most recently
    logic       gnt_q, gnt_d;             // port owning the in-flight access
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata0_q, rdata0_d;
    logic [7:0] rdata1_q, rdata1_d;
    logic [7:0] count0_q, count0_d;
    logic [7:0] count1_q, count1_d;

    logic       grant_valid;
    logic       grant_port;
    logic       in_access;
    logic       in_done;

    // State register; reset leaves last grant on port 1 so port 0 wins the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            rdata0_q   <= 8'h00;
            rdata1_q   <= 8'h00;
            count0_q   <= 8'h00;
            count1_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            count0_q   <= count0_d;
            count1_q   <= count1_d;
        end
    end

    // Next-state, arbitration, read capture and counter update.
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        count0_d    = count0_q;
        count1_d    = count1_q;
        grant_valid = 1'b0;
        grant_port  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Req0 && Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = ~last_gnt_q;
                end else if (Req0) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b0;
                end else if (Req1) begin
                    grant_valid = 1'b1;
                    grant_port  = 1'b1;
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!we_q) begin
                    if (gnt_q) rdata1_d = MemDataOut;
                    else       rdata0_d = MemDataOut;
                end
            end
            DONE: begin
                state_d = IDLE;
                // The acked port's own request is still high this cycle; only
                // the other port may be granted back-to-back.
                if (gnt_q) begin
                    count1_d = count1_q + 8'd1;
                    if (Req0) begin
                        grant_valid = 1'b1;
                        grant_port  = 1'b0;
                    end
                end else begin
                    count0_d = count0_q + 8'd1;
                    if (Req1) begin
                        grant_valid = 1'b1;
                        grant_port  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_valid) begin
            state_d    = ACCESS;
            gnt_d      = grant_port;
            last_gnt_d = grant_port;
            we_d       = grant_port ? We1    : We0;
            addr_d     = grant_port ? Addr1  : Addr0;
            wdata_d    = grant_port ? Wdata1 : Wdata0;
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_done   = (state_q == DONE);

    // Reset gates the write strobe combinationally so an aborted write never lands.
    assign MemWriteEn = in_access & we_q & ~Reset;
    assign MemToReg   = in_access & ~we_q;
    assign MemAddress = in_access ? addr_q  : 8'h00;
    assign MemDataIn  = in_access ? wdata_q : 8'h00;

    assign Ack0   = in_done & ~gnt_q & ~Reset;
    assign Ack1   = in_done &  gnt_q & ~Reset;
    assign Busy   = (state_q != IDLE) & ~Reset;
    assign Rdata0 = rdata0_q;
    assign Rdata1 = rdata1_q;
    assign Count0 = count0_q;
    assign Count1 = count1_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter with a simple
//                behavioural data memory (addr i holds i, except 0x02 = 0x55).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic       Clk;
    logic       Reset;
    logic       Req0, We0, Req1, We1;
    logic [7:0] Addr0, Wdata0, Addr1, Wdata1;
    logic       Ack0, Ack1;
    logic [7:0] Rdata0, Rdata1;
    logic       MemWriteEn, MemToReg;
    logic [7:0] MemAddress, MemDataIn, MemDataOut;
    logic [7:0] Count0, Count1;
    logic       Busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem [0:255];

    dmem_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req0       (Req0),
        .We0        (We0),
        .Addr0      (Addr0),
        .Wdata0     (Wdata0),
        .Ack0       (Ack0),
        .Rdata0     (Rdata0),
        .Req1       (Req1),
        .We1        (We1),
        .Addr1      (Addr1),
        .Wdata1     (Wdata1),
        .Ack1       (Ack1),
        .Rdata1     (Rdata1),
        .MemWriteEn (MemWriteEn),
        .MemToReg   (MemToReg),
        .MemAddress (MemAddress),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut),
        .Count0     (Count0),
        .Count1     (Count1),
        .Busy       (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural memory: reset-initialised contents, write on rising edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
        mem[8'h02] = 8'h55;
        forever begin
            @(posedge Clk);
            if (MemWriteEn) mem[MemAddress] <= MemDataIn;
        end
    end
    assign MemDataOut = mem[MemAddress];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Issue one request, hold until Ack (bounded), then drop it.
    task automatic run_txn(input bit port, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, output int lat,
                           output int we_cyc, output int other_ack);
        bit acked;
        acked = 1'b0;
        lat = 0; we_cyc = 0; other_ack = 0;
        if (port) begin Req1 = 1'b1; We1 = we; Addr1 = addr; Wdata1 = wdata; end
        else      begin Req0 = 1'b1; We0 = we; Addr0 = addr; Wdata0 = wdata; end
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            lat++;
            if (MemWriteEn) we_cyc++;
            if (port ? Ack0 : Ack1) other_ack++;
            if (port ? Ack1 : Ack0) acked = 1'b1;
        end
        if (!acked) check("ack_timeout", 32'd0, 32'd1);
        Req0 = 1'b0; Req1 = 1'b0; We0 = 1'b0; We1 = 1'b0;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, wec, oth;
        Reset = 1'b1;
        Req0 = 1'b0; We0 = 1'b0; Addr0 = 8'h00; Wdata0 = 8'h00;
        Req1 = 1'b0; We1 = 1'b0; Addr1 = 8'h00; Wdata1 = 8'h00;
        tick(); tick();

        // reset state
        check("rst_ack0",   Ack0, 0);
        check("rst_ack1",   Ack1, 0);
        check("rst_busy",   Busy, 0);
        check("rst_cnt0",   Count0, 0);
        check("rst_cnt1",   Count1, 0);
        check("rst_rdata0", Rdata0, 0);
        check("rst_rdata1", Rdata1, 0);
        check("rst_we",     MemWriteEn, 0);
        Reset = 1'b0;
        tick();

        // single read on port 1
        run_txn(1'b1, 1'b0, 8'h02, 8'h00, lat, wec, oth);
        check("rd1_latency", lat, 2);
        check("rd1_rdata",   Rdata1, 8'h55);
        check("rd1_cnt1",    Count1, 1);
        check("rd1_no_ack0", oth, 0);
        check("rd1_idle",    Busy, 0);

        // write then read on port 0
        run_txn(1'b0, 1'b1, 8'h40, 8'hA7, lat, wec, oth);
        check("wr0_latency", lat, 2);
        check("wr0_we_cyc",  wec, 1);
        check("wr0_mem",     mem[8'h40], 8'hA7);
        check("wr0_cnt0",    Count0, 1);
        run_txn(1'b0, 1'b0, 8'h40, 8'h00, lat, wec, oth);
        check("rd0_rdata",   Rdata0, 8'hA7);
        check("rd0_we_cyc",  wec, 0);
        check("rd0_cnt0",    Count0, 2);
        check("rd1_held",    Rdata1, 8'h55);
        // read-after-write from the other port
        run_txn(1'b1, 1'b0, 8'h40, 8'h00, lat, wec, oth);
        check("raw1_rdata",  Rdata1, 8'hA7);
        check("raw1_cnt1",   Count1, 2);

        // contention after a fresh reset: order 0,1,0,1 with Acks every 2 cycles
        Reset = 1'b1;
        tick();
        check("rst2_cnt0", Count0, 0);
        Reset = 1'b0;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 8'h40;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 8'h02;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check($sformatf("cont_ack0_c%0d", i), Ack0, (i == 2 || i == 6));
            check($sformatf("cont_ack1_c%0d", i), Ack1, (i == 4 || i == 8));
        end
        Req0 = 1'b0; Req1 = 1'b0;
        tick();
        check("cont_rdata0", Rdata0, 8'hA7);
        check("cont_rdata1", Rdata1, 8'h55);
        check("cont_cnt0",   Count0, 2);
        check("cont_cnt1",   Count1, 2);
        check("cont_idle",   Busy, 0);

        // reset in the middle of a port 1 write
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 8'h10; Wdata1 = 8'hFF;
        tick();
        check("abort_we_pre", MemWriteEn, 1);
        Reset = 1'b1;
        #1;
        check("abort_we_gated", MemWriteEn, 0);
        tick();
        check("abort_ack1", Ack1, 0);
        check("abort_busy", Busy, 0);
        Req1 = 1'b0; We1 = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        check("abort_ack1_post", Ack1, 0);
        check("abort_cnt1",      Count1, 0);
        check("abort_mem",       mem[8'h10], 8'h10);

        // counter wrap on port 0
        for (int n = 0; n < 256; n++) begin
            run_txn(1'b0, 1'b0, 8'h00, 8'h00, lat, wec, oth);
            if (n == 254) check("wrap_cnt0_255", Count0, 8'hFF);
        end
        check("wrap_cnt0", Count0, 8'h00);
        check("wrap_cnt1", Count1, 8'h00);

        // idle: nothing moves for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("idle_c%0d", i),
                  {Busy, MemWriteEn, MemToReg, MemAddress, MemDataIn, Ack0, Ack1}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset; Reset SHALL be synchronous and active-high, sampled only on the rising edge of Clk.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous active-high reset.
REQ-004 Req0  input  1  port 0 (core load/store) access request; held high until Ack0.
REQ-005 We0  input  1  port 0 write (1) / read (0); stable while Req0 high.
REQ-006 Addr0  input  8  port 0 memory address; stable while Req0 high.
REQ-007 Wdata0  input  8  port 0 write data; stable while Req0 high.
REQ-008 Ack0  output  1  one-cycle completion pulse for port 0.
REQ-009 Rdata0  output  8  port 0 read data; valid in the Ack0 cycle, held until next port 0 read completes.
REQ-010 Req1, We1, Addr1, Wdata1, Ack1, Rdata1  same directions/widths/meanings as port 0, for port 1 (loader/debug).
REQ-011 MemWriteEn  output  1  drives data memory WriteEn.
REQ-012 MemToReg  output  1  drives data memory MemToReg; 1 selects memory contents on MemDataOut.
REQ-013 MemAddress  output  8  drives data memory DataAddress.
REQ-014 MemDataIn  output  8  drives data memory DataIn.
REQ-015 MemDataOut  input  8  combinational read data from data memory.
REQ-016 Count0, Count1  output  8  completed-transaction counters per port, wrap modulo 256.
REQ-017 Busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, DONE, encoded in a registered state variable.
REQ-019 IDLE: if any Req is high, latch the winner's We/Addr/Wdata and port id, go to ACCESS; else stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: if both requests are high, grant the port not granted last; if one request is high, grant it; LastGnt updates only on grant.
REQ-021 ACCESS (exactly one cycle): MemAddress = latched Addr; MemDataIn = latched Wdata; MemWriteEn = latched We; MemToReg = NOT latched We; on the closing edge, capture MemDataOut into the granted port's Rdata when the access is a read.
REQ-022 Outside ACCESS: MemWriteEn = 0, MemToReg = 0, MemAddress = 0, MemDataIn = 0.
REQ-023 DONE: the granted port's Ack SHALL be high for exactly this one cycle; that port's Count increments by 1 (255 wraps to 0) on the closing edge.
REQ-024 DONE arbitration: only the other port's Req is eligible (the acked port's Req is ignored this cycle); if it is high, latch it and go to ACCESS; else go to IDLE.
REQ-025 Latency: Req rising edge sampled in IDLE at edge T -> ACCESS in cycle T+1 -> Ack in cycle T+2.
REQ-026 A write SHALL update memory at the edge ending ACCESS; read-after-write to the same address by any port SHALL return the new value.
REQ-027 Ack0 and Ack1 SHALL never be high in the same cycle; at most one memory access SHALL occur per ACCESS cycle.
REQ-028 A Req deasserted before its Ack is a protocol violation; the block completes the latched access regardless.

Reset
REQ-029 While Reset is high: state <= IDLE, LastGnt <= port 1 (so port 0 wins the first tie), Ack0 = Ack1 = 0, Rdata0 = Rdata1 = 0, Count0 = Count1 = 0, Busy = 0.
REQ-030 MemWriteEn SHALL be combinationally forced to 0 whenever Reset is high, including mid-ACCESS, so an aborted write never reaches memory.
REQ-031 Reset asserted in ACCESS or DONE SHALL discard the in-flight access with no Ack and no counter change.

Verification
REQ-032 Single read: memory reset-initialised, Req1=1, We1=0, Addr1=0x02 -> Ack1 two cycles later, Rdata1=0x55, Count1=1, Ack0 stays 0.
REQ-033 Write then read: port 0 writes 0xA7 to 0x40, then reads 0x40 -> second Ack0 with Rdata0=0xA7; MemWriteEn high for exactly one cycle.
REQ-034 Contention: Req0 and Req1 both high continuously after reset -> grant order 0,1,0,1; Acks spaced 2 cycles apart; no Ack overlap.
REQ-035 Reset mid-write: port 1 write 0xFF to 0x10; Reset asserted during ACCESS -> MemWriteEn=0, no Ack1, Count1=0, address 0x10 holds its reset value.
REQ-036 Counter wrap: 256 port 0 transactions -> Count0 returns to 0x00; Count1 unchanged.
REQ-037 Idle check: no requests for 20 cycles -> Busy=0, all Mem* outputs 0, no Acks.
